// File: rtl/disp_compose.sv
// Sprite compositor: turns VGA driver pixel requests into sprite ROM addresses and
// produces colour-keyed RGB, with the sync signals delayed by the same amount.
module disp_compose #(
  parameter int              X_W       = 10,
  parameter int              Y_W       = 10,
  parameter int              SPR_W     = 32,
  parameter int              SPR_H     = 32,
  parameter int              RD_DELAY  = 2,
  parameter int              RGB_W     = 12,
  parameter logic [RGB_W-1:0] BG_COLOR  = 12'h000,
  parameter logic [RGB_W-1:0] KEY_COLOR = 12'hF0F,
  localparam int             ADDR_W    = $clog2(SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic              disp_i,
  input  logic              req_i,
  input  logic [X_W-1:0]    req_x_i,
  input  logic [Y_W-1:0]    req_y_i,
  input  logic [X_W-1:0]    pos_x_i,
  input  logic [Y_W-1:0]    pos_y_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [RGB_W-1:0]  rom_data_i,
  output logic [RGB_W-1:0]  rgb_o,
  output logic              h_sync_o,
  output logic              v_sync_o,
  output logic [7:0]        frame_o
);

  localparam int L = RD_DELAY + 1;
  localparam logic [X_W:0] SPR_W_EXT = (X_W + 1)'(SPR_W);
  localparam logic [Y_W:0] SPR_H_EXT = (Y_W + 1)'(SPR_H);

  // Flag bit positions inside each pipeline stage
  localparam int F_HIT = 3;
  localparam int F_DISP = 2;
  localparam int F_HS = 1;
  localparam int F_VS = 0;

  logic              vs_prev_q;
  logic [X_W-1:0]    px_q, px_d;
  logic [Y_W-1:0]    py_q, py_d;
  logic [7:0]        frame_q, frame_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [L-1:0][3:0] pipe_q;
  logic [3:0]        flags_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, vs_q;

  logic              capture;
  logic              hit;
  logic [X_W:0]      rx_ext, px_ext, dx;
  logic [Y_W:0]      ry_ext, py_ext, dy;

  assign capture = vs_prev_q & ~v_sync_i;

  // One extra bit so px+SPR_W past the screen edge clips instead of wrapping.
  assign rx_ext = {1'b0, req_x_i};
  assign px_ext = {1'b0, px_q};
  assign ry_ext = {1'b0, req_y_i};
  assign py_ext = {1'b0, py_q};
  assign dx     = rx_ext - px_ext;
  assign dy     = ry_ext - py_ext;

  // Uses the px/py held before any capture in this same cycle.
  assign hit = req_i
             && (rx_ext >= px_ext) && (rx_ext < px_ext + SPR_W_EXT)
             && (ry_ext >= py_ext) && (ry_ext < py_ext + SPR_H_EXT);

  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    frame_d = frame_q;
    if (capture) begin
      px_d    = pos_x_i;
      py_d    = pos_y_i;
      frame_d = frame_q + 8'd1;
    end
  end

  always_comb begin
    addr_d = '0;
    if (hit) begin
      addr_d = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    end
  end

  always_comb begin
    flags_d         = '0;
    flags_d[F_HIT]  = hit;
    flags_d[F_DISP] = disp_i;
    flags_d[F_HS]   = h_sync_i;
    flags_d[F_VS]   = v_sync_i;
  end

  // The last stage lines up with rom_data_i for the same pixel.
  always_comb begin
    rgb_d = BG_COLOR;
    if (!pipe_q[L-1][F_DISP]) begin
      rgb_d = '0;
    end else if (pipe_q[L-1][F_HIT] && (rom_data_i != KEY_COLOR)) begin
      rgb_d = rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      frame_q   <= '0;
      addr_q    <= '0;
      pipe_q    <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      vs_prev_q <= v_sync_i;
      px_q      <= px_d;
      py_q      <= py_d;
      frame_q   <= frame_d;
      addr_q    <= addr_d;
      pipe_q    <= {pipe_q[L-2:0], flags_d};
      rgb_q     <= rgb_d;
      hs_q      <= pipe_q[L-1][F_HS];
      vs_q      <= pipe_q[L-1][F_VS];
    end
  end

  assign rom_addr_o = addr_q;
  assign rgb_o      = rgb_q;
  assign h_sync_o   = hs_q;
  assign v_sync_o   = vs_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_disp_compose.sv
// Directed bench for disp_compose with a two-cycle-latency sprite ROM model.
module tb_disp_compose;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_sync_i = 1'b0;
  logic        v_sync_i = 1'b1;
  logic        disp_i = 1'b1;
  logic        req_i = 1'b0;
  logic [9:0]  req_x_i = '0;
  logic [9:0]  req_y_i = '0;
  logic [9:0]  pos_x_i = 10'd100;
  logic [9:0]  pos_y_i = 10'd50;
  logic [9:0]  rom_addr_o;
  logic [11:0] rom_data_i;
  logic [11:0] rgb_o;
  logic        h_sync_o;
  logic        v_sync_o;
  logic [7:0]  frame_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_frame = 8'd0;

  logic [11:0] rd1, rd2;

  disp_compose dut (
    .clk       (clk),
    .rst       (rst),
    .h_sync_i  (h_sync_i),
    .v_sync_i  (v_sync_i),
    .disp_i    (disp_i),
    .req_i     (req_i),
    .req_x_i   (req_x_i),
    .req_y_i   (req_y_i),
    .pos_x_i   (pos_x_i),
    .pos_y_i   (pos_y_i),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .rgb_o     (rgb_o),
    .h_sync_o  (h_sync_o),
    .v_sync_o  (v_sync_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents used by the directed vectors.
  function automatic logic [11:0] rom_f(input logic [9:0] a);
    case (a)
      10'd0:    return 12'h0F0;
      10'd1:    return 12'hABC;
      10'd297:  return 12'h456;
      10'd1023: return 12'hF0F;
      default:  return 12'h321;
    endcase
  endfunction

  always @(posedge clk) begin
    rd1 <= rom_f(rom_addr_o);
    rd2 <= rd1;
  end
  assign rom_data_i = rd2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("%s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // v_sync high then low then high again: one falling edge, one capture.
  task automatic capture(input string tag, input bit do_check);
    v_sync_i = 1'b1;
    tick();
    v_sync_i = 1'b0;
    tick();
    exp_frame = exp_frame + 8'd1;
    if (do_check) chk({tag, "_frame"}, 32'(frame_o), 32'(exp_frame));
    v_sync_i = 1'b1;
    tick();
  endtask

  // One request, address checked one edge later, colour four edges later.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic d, input logic [9:0] exp_addr, input logic [11:0] exp_rgb);
    req_i   = 1'b1;
    req_x_i = x;
    req_y_i = y;
    disp_i  = d;
    tick();
    chk({tag, "_addr"}, 32'(rom_addr_o), 32'(exp_addr));
    req_i  = 1'b0;
    disp_i = 1'b1;
    tick();
    tick();
    tick();
    chk({tag, "_rgb"}, 32'(rgb_o), 32'(exp_rgb));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_rgb", 32'(rgb_o), 32'h0);
    chk("rst_addr", 32'(rom_addr_o), 32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);
    chk("rst_hs", 32'(h_sync_o), 32'h0);
    chk("rst_vs", 32'(v_sync_o), 32'h0);
    rst = 1'b0;
    tick();

    // Frame counter wrap: first capture gives 1, 256 in total gives 0
    capture("cap1", 1'b1);
    for (int i = 0; i < 255; i++) capture("capw", 1'b0);
    chk("frame_wrap", 32'(frame_o), 32'h0);

    // Basic pixel and colour key at pos (100,50)
    pix("basic", 10'd100, 10'd50, 1'b1, 10'd0, 12'h0F0);
    pix("plain", 10'd101, 10'd50, 1'b1, 10'd1, 12'hABC);
    pix("key", 10'd131, 10'd81, 1'b1, 10'd1023, 12'h000);
    pix("right_out", 10'd132, 10'd50, 1'b1, 10'd0, 12'h000);
    pix("above", 10'd100, 10'd49, 1'b1, 10'd0, 12'h000);

    // Blanking masks a hit
    pix("blank", 10'd100, 10'd50, 1'b0, 10'd0, 12'h000);

    // Mid-frame position change is ignored until the next fall
    pos_x_i = 10'd200;
    pix("mid_old", 10'd100, 10'd50, 1'b1, 10'd0, 12'h0F0);
    capture("cap_mid", 1'b1);
    pix("mid_gone", 10'd100, 10'd50, 1'b1, 10'd0, 12'h000);
    pix("mid_new", 10'd200, 10'd50, 1'b1, 10'd0, 12'h0F0);

    // Capture and request in the same cycle: request uses old px/py (200,50)
    pos_x_i  = 10'd0;
    pos_y_i  = 10'd0;
    req_i    = 1'b1;
    req_x_i  = 10'd201;
    req_y_i  = 10'd50;
    v_sync_i = 1'b0;
    tick();
    exp_frame = exp_frame + 8'd1;
    chk("simul_addr", 32'(rom_addr_o), 32'd1);
    chk("simul_frame", 32'(frame_o), 32'(exp_frame));
    req_i    = 1'b0;
    v_sync_i = 1'b1;
    tick();
    tick();
    tick();
    chk("simul_rgb", 32'(rgb_o), 32'hABC);
    pix("simul_after", 10'd0, 10'd0, 1'b1, 10'd0, 12'h0F0);

    // Clipping at the bottom-right corner
    pos_x_i = 10'd630;
    pos_y_i = 10'd470;
    capture("cap_clip", 1'b1);
    pix("clip_in", 10'd639, 10'd479, 1'b1, 10'd297, 12'h456);
    pix("clip_wrap", 10'd5, 10'd5, 1'b1, 10'd0, 12'h000);

    // Sync delay: one-cycle h pulse and v dip, seen 4 edges later
    h_sync_i = 1'b1;
    v_sync_i = 1'b0;
    tick();
    exp_frame = exp_frame + 8'd1;
    h_sync_i = 1'b0;
    v_sync_i = 1'b1;
    tick();
    tick();
    chk("sync_e3_hs", 32'(h_sync_o), 32'h0);
    chk("sync_e3_vs", 32'(v_sync_o), 32'h1);
    tick();
    chk("sync_e4_hs", 32'(h_sync_o), 32'h1);
    chk("sync_e4_vs", 32'(v_sync_o), 32'h0);
    tick();
    chk("sync_e5_hs", 32'(h_sync_o), 32'h0);
    chk("sync_e5_vs", 32'(v_sync_o), 32'h1);

    // Reset mid-line with a visible pixel in flight at pos (630,470)
    req_i   = 1'b1;
    req_x_i = 10'd630;
    req_y_i = 10'd470;
    tick();
    req_i = 1'b0;
    rst   = 1'b1;
    tick();
    exp_frame = 8'd0;
    chk("mrst_rgb", 32'(rgb_o), 32'h0);
    chk("mrst_addr", 32'(rom_addr_o), 32'h0);
    chk("mrst_frame", 32'(frame_o), 32'h0);
    chk("mrst_hs", 32'(h_sync_o), 32'h0);
    chk("mrst_vs", 32'(v_sync_o), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mrst_flush%0d", i), 32'(rgb_o), 32'h0);
    end

    // First post-reset request: px/py are 0, pixel shows on the 4th edge only
    req_i   = 1'b1;
    req_x_i = 10'd0;
    req_y_i = 10'd0;
    tick();
    chk("post_addr", 32'(rom_addr_o), 32'd0);
    req_i = 1'b0;
    tick();
    tick();
    chk("post_e3_rgb", 32'(rgb_o), 32'h000);
    tick();
    chk("post_e4_rgb", 32'(rgb_o), 32'h0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_compose.md
DISP_COMPOSE -- requirements
Module: disp_compose

Interface
REQ-001 Parameter X_W, default 10: width of the display x coordinate.
REQ-002 Parameter Y_W, default 10: width of the display y coordinate.
REQ-003 Parameter SPR_W, default 32: sprite width in pixels; SHALL be a power of 2.
REQ-004 Parameter SPR_H, default 32: sprite height in pixels.
REQ-005 Parameter RD_DELAY, default 2: sprite ROM read latency in clk cycles; SHALL be at least 1.
REQ-006 Parameter RGB_W, default 12: pixel colour width.
REQ-007 Parameter BG_COLOR, default 12'h000: background colour.
REQ-008 Parameter KEY_COLOR, default 12'hF0F: transparent colour key.
REQ-009 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-010 Port rst, input, 1: reset, synchronous and active-high.
REQ-011 Port h_sync_i, input, 1: horizontal sync from the VGA driver.
REQ-012 Port v_sync_i, input, 1: vertical sync from the VGA driver (low during the sync pulse).
REQ-013 Port disp_i, input, 1: driver visible-area flag.
REQ-014 Port req_i, input, 1: driver address-request valid.
REQ-015 Port req_x_i, input, X_W: requested x coordinate.
REQ-016 Port req_y_i, input, Y_W: requested y coordinate.
REQ-017 Port pos_x_i, input, X_W: sprite top-left x, supplied by game logic.
REQ-018 Port pos_y_i, input, Y_W: sprite top-left y, supplied by game logic.
REQ-019 Port rom_addr_o, output, log2(SPR_W*SPR_H): sprite ROM address.
REQ-020 Port rom_data_i, input, RGB_W: sprite ROM data, valid RD_DELAY cycles after rom_addr_o changes.
REQ-021 Port rgb_o, output, RGB_W: pixel colour.
REQ-022 Port h_sync_o, output, 1: delayed h_sync_i.
REQ-023 Port v_sync_o, output, 1: delayed v_sync_i.
REQ-024 Port frame_o, output, 8: frame counter for animation.

Function
REQ-025 Position latch: when v_sync_i is 1 in the previous cycle and 0 in the current one, pos_x_i/pos_y_i SHALL be captured into px/py; px/py SHALL be constant for the rest of the frame.
REQ-026 frame_o SHALL increment by 1 on each capture and wrap from 255 to 0.
REQ-027 Hit SHALL be asserted when req_i=1, px <= req_x_i < px+SPR_W, and py <= req_y_i < py+SPR_H.
REQ-028 The comparisons in REQ-027 SHALL use X_W+1 and Y_W+1 bit arithmetic, so a sprite overhanging the right or bottom edge clips and never wraps.
REQ-029 rom_addr_o SHALL be registered and equal (req_y_i-py)*SPR_W + (req_x_i-px) when hit, else 0.
REQ-030 hit, disp_i, h_sync_i and v_sync_i SHALL pass through a shift pipeline of L = RD_DELAY+1 stages, so the delayed flags align with rom_data_i.
REQ-031 rgb_o (registered) SHALL be:
- 0 when the delayed disp is 0;
- rom_data_i when the delayed hit is 1 and rom_data_i != KEY_COLOR;
- BG_COLOR otherwise.
REQ-032 h_sync_o and v_sync_o SHALL be delayed by exactly L+1 cycles, the same total latency as rgb_o.
REQ-033 Input-to-output latency SHALL be fixed at L+1 cycles for every pixel, with no stalls.
REQ-034 A position change mid-frame SHALL have no effect until the next capture.
REQ-035 Simultaneous capture and pixel request: the request SHALL use the px/py held before the capture.

Reset
REQ-036 While rst=1, the following SHALL be 0 at the next edge:
- all pipeline stages;
- px, py, frame_o, rom_addr_o, rgb_o;
- h_sync_o, v_sync_o.
REQ-037 After rst deasserts, outputs SHALL be valid L+1 cycles later; rst asserted mid-line SHALL flush the pipeline with no stale pixel emitted afterwards.

Verification
REQ-038 Basic pixel: pos=(100,50), then a v_sync fall, then request x=100,y=50, rom_data=12'h0F0 -> rom_addr_o=0; rgb_o=12'h0F0 after 4 cycles (RD_DELAY=2).
REQ-039 Colour key: request x=131,y=81 -> rom_addr_o=1023; rom_data=KEY_COLOR -> rgb_o=BG_COLOR.
REQ-040 Clipping: pos=(630,470), request x=639,y=479 -> hit, addr=9*32+9=297; request x=5,y=5 -> no hit, rgb_o=BG_COLOR.
REQ-041 Blanking: disp_i=0 with hit=1 -> rgb_o=0; h_sync_o/v_sync_o equal the inputs delayed 4 cycles.
REQ-042 Frame counter: 256 v_sync falls -> frame_o returns to 0; pos_x_i changed mid-frame -> no effect on hits until the next fall.
REQ-043 Reset: rst pulsed for 1 cycle mid-line -> all outputs 0 on the next edge; the first valid pixel appears 4 cycles after the first post-reset request.
